// File: rtl/hitbox_pkg.sv
// hitbox_pkg: shared constants, state type and width helper for the hit scheduler
package hitbox_pkg;
  localparam int COORD_W_DFLT = 10;
  localparam int DIST_W_DFLT = 2 * COORD_W_DFLT + 2;
  localparam int DRAIN_CYCLES = 2;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  function automatic int dist_w(input int cw);
    return 2 * cw + 2;
  endfunction
endpackage

// File: rtl/hit_scheduler_if.sv
// hit_scheduler_if: slot/target inputs and mask outputs of the hit scheduler
interface hit_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W = 10
);
  logic frame_start;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_x;
  logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_y;
  logic [NUM_SLOTS-1:0][COORD_W-1:0] slot_r;
  logic [COORD_W-1:0] target_x;
  logic [COORD_W-1:0] target_y;
  logic [COORD_W-1:0] target_r;
  logic busy;
  logic result_valid;
  logic [NUM_SLOTS-1:0] hit_mask;
  logic [NUM_SLOTS-1:0] new_hit_mask;
  logic overrun;
  modport master (
    output frame_start, slot_valid, slot_x, slot_y, slot_r, target_x, target_y, target_r,
    input busy, result_valid, hit_mask, new_hit_mask, overrun
  );
  modport slave (
    input frame_start, slot_valid, slot_x, slot_y, slot_r, target_x, target_y, target_r,
    output busy, result_valid, hit_mask, new_hit_mask, overrun
  );
endinterface

// File: rtl/hitbox_dist_pipe.sv
// hitbox_dist_pipe: two-stage circle-contact test, deltas then squared-distance compare
module hitbox_dist_pipe
  import hitbox_pkg::*;
#(
  parameter int COORD_W = COORD_W_DFLT,
  parameter int IDX_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic [IDX_W-1:0] issue_idx,
  input  logic [COORD_W-1:0] slot_x,
  input  logic [COORD_W-1:0] slot_y,
  input  logic [COORD_W-1:0] slot_r,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  input  logic [COORD_W-1:0] target_r,
  output logic res_valid,
  output logic [IDX_W-1:0] res_idx,
  output logic res_hit
);
  localparam int DW = dist_w(COORD_W);
  logic s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0] rs;
  logic signed [DW-1:0] dxe, dye;
  logic [DW-1:0] d2, rs2;
  // full-width squares: sign-extend deltas so nothing wraps or truncates
  always_comb begin
    dxe = DW'(dx);
    dye = DW'(dy);
    d2 = $unsigned(dxe * dxe) + $unsigned(dye * dye);
    rs2 = DW'(rs) * DW'(rs);
  end
  // stage 1: signed deltas and radius sum
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx <= '0;
      dx <= '0;
      dy <= '0;
      rs <= '0;
    end else begin
      s1_valid <= issue_valid;
      s1_idx <= issue_idx;
      dx <= $signed({1'b0, target_x}) - $signed({1'b0, slot_x});
      dy <= $signed({1'b0, target_y}) - $signed({1'b0, slot_y});
      rs <= {1'b0, slot_r} + {1'b0, target_r};
    end
  end
  // stage 2: inclusive contact compare
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_idx <= '0;
      res_hit <= 1'b0;
    end else begin
      res_valid <= s1_valid;
      res_idx <= s1_idx;
      res_hit <= d2 <= rs2;
    end
  end
endmodule

// File: rtl/hit_scheduler.sv
// hit_scheduler: per-frame scan of attack slots against one target through a shared distance pipe
module hit_scheduler
  import hitbox_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W = COORD_W_DFLT
) (
  input logic Clk,
  input logic Reset,
  hit_scheduler_if.slave bus
);
  localparam int IDX_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLOTS - 1);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic drain_cnt;
  logic [COORD_W-1:0] tx, ty, tr;
  logic [NUM_SLOTS-1:0] shadow, shadow_nxt, prev, hit_q, new_q;
  logic overrun_q;
  logic issue_valid;
  logic res_valid, res_hit;
  logic [IDX_W-1:0] res_idx;
  // next state, issue qualifier and shadow accumulation
  always_comb begin
    state_nxt = state == IDLE ? (bus.frame_start ? SCAN : IDLE) :
                state == SCAN ? (idx == LAST ? DRAIN : SCAN) :
                state == DRAIN ? (drain_cnt == 1'(DRAIN_CYCLES - 1) ? DONE : DRAIN) : IDLE;
    issue_valid = state == SCAN && bus.slot_valid[idx];
    shadow_nxt = shadow | (res_valid && res_hit ? NUM_SLOTS'(1) << res_idx : '0);
  end
  // invalid slots never enter the pipe valid, so their bit stays 0
  hitbox_dist_pipe #(.COORD_W(COORD_W), .IDX_W(IDX_W)) u_pipe (
    .clk(Clk),
    .rst(Reset),
    .issue_valid(issue_valid),
    .issue_idx(idx),
    .slot_x(bus.slot_x[idx]),
    .slot_y(bus.slot_y[idx]),
    .slot_r(bus.slot_r[idx]),
    .target_x(tx),
    .target_y(ty),
    .target_r(tr),
    .res_valid(res_valid),
    .res_idx(res_idx),
    .res_hit(res_hit)
  );
  // state, target snapshot, shadow/prev masks and published masks
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      drain_cnt <= 1'b0;
      tx <= '0;
      ty <= '0;
      tr <= '0;
      shadow <= '0;
      prev <= '0;
      hit_q <= '0;
      new_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= state == SCAN ? idx + 1'b1 : '0;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : 1'b0;
      shadow <= state == IDLE ? '0 : shadow_nxt;
      if (state == IDLE && bus.frame_start) begin
        tx <= bus.target_x;
        ty <= bus.target_y;
        tr <= bus.target_r;
      end
      if (state == DRAIN && state_nxt == DONE) begin
        hit_q <= shadow_nxt;
        new_q <= shadow_nxt & ~prev;
        prev <= shadow_nxt;
      end
      if (bus.frame_start && state != IDLE) overrun_q <= 1'b1;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.result_valid = state == DONE;
  assign bus.hit_mask = hit_q;
  assign bus.new_hit_mask = new_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_hit_scheduler.sv
// tb_hit_scheduler: directed frames with a result scoreboard checked by an independent monitor
module tb_hit_scheduler;
  typedef struct {
    logic [3:0] hit;
    logic [3:0] nw;
    int cyc;
  } exp_t;
  logic Clk = 0;
  logic Reset = 1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  hit_scheduler_if #(.NUM_SLOTS(4), .COORD_W(10)) bus ();
  hit_scheduler #(.NUM_SLOTS(4), .COORD_W(10)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: every result_valid pulse must match the oldest expected frame
  always @(negedge Clk) begin
    if (bus.result_valid) begin
      if (q.size() == 0) chk("unexpected_result_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result_cycle", cyc, e.cyc);
        chk("hit_mask", int'(bus.hit_mask), int'(e.hit));
        chk("new_hit_mask", int'(bus.new_hit_mask), int'(e.nw));
      end
    end
  end
  task automatic start(input logic [3:0] hit, input logic [3:0] nw);
    exp_t e;
    @(posedge Clk);
    #1;
    bus.frame_start = 1;
    e.hit = hit;
    e.nw = nw;
    e.cyc = cyc + 7;
    q.push_back(e);
    @(posedge Clk);
    #1;
    bus.frame_start = 0;
  endtask
  task automatic settle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (bus.busy) chk("busy_timeout", 1, 0);
  endtask
  task automatic frame(input logic [3:0] hit, input logic [3:0] nw);
    start(hit, nw);
    settle();
  endtask
  task automatic set_target(input int x, input int y, input int r);
    bus.target_x = 10'(x);
    bus.target_y = 10'(y);
    bus.target_r = 10'(r);
  endtask
  task automatic set_slot(input int i, input int x, input int y, input int r);
    bus.slot_x[i] = 10'(x);
    bus.slot_y[i] = 10'(y);
    bus.slot_r[i] = 10'(r);
  endtask
  initial begin
    bus.frame_start = 0;
    bus.slot_valid = '0;
    bus.slot_x = '0;
    bus.slot_y = '0;
    bus.slot_r = '0;
    set_target(0, 0, 0);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_result_valid", int'(bus.result_valid), 0);
    chk("rst_hit_mask", int'(bus.hit_mask), 0);
    chk("rst_new_hit_mask", int'(bus.new_hit_mask), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    set_target(100, 100, 10);
    set_slot(0, 106, 108, 0);
    bus.slot_valid = 4'b0001;
    start(4'b0001, 4'b0001);
    chk("busy_in_scan", int'(bus.busy), 1);
    set_target(900, 900, 0);
    settle();
    set_target(100, 100, 10);
    set_slot(0, 107, 108, 0);
    frame(4'b0000, 4'b0000);
    set_target(0, 0, 0);
    bus.slot_valid = 4'b0010;
    set_slot(1, 1023, 0, 1023);
    frame(4'b0010, 4'b0010);
    set_slot(1, 1023, 0, 1022);
    frame(4'b0000, 4'b0000);
    set_target(500, 500, 5);
    set_slot(2, 503, 504, 0);
    bus.slot_valid = 4'b0000;
    frame(4'b0000, 4'b0000);
    bus.slot_valid = 4'b0100;
    frame(4'b0100, 4'b0100);
    frame(4'b0100, 4'b0000);
    chk("overrun_before", int'(bus.overrun), 0);
    start(4'b0100, 4'b0000);
    repeat (2) @(posedge Clk);
    #1;
    bus.frame_start = 1;
    @(posedge Clk);
    #1;
    bus.frame_start = 0;
    settle();
    chk("overrun_set", int'(bus.overrun), 1);
    frame(4'b0100, 4'b0000);
    chk("overrun_sticky", int'(bus.overrun), 1);
    @(posedge Clk);
    #1;
    bus.frame_start = 1;
    @(posedge Clk);
    #1;
    bus.frame_start = 0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1;
    @(posedge Clk);
    #1;
    Reset = 0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_hit_mask", int'(bus.hit_mask), 0);
    chk("abort_new_hit_mask", int'(bus.new_hit_mask), 0);
    chk("abort_overrun", int'(bus.overrun), 0);
    repeat (6) @(posedge Clk);
    #1;
    frame(4'b0100, 4'b0100);
    repeat (4) @(posedge Clk);
    #1;
    chk("pending_results", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
